sd_spi_byte: RTL and testbench
==============================

Name: sd_spi_byte

Overview:
- Byte-level SPI transceiver for the SD card interface.
- Sits directly downstream of the SD clock divider. It enables the divider, watches the divided serial clock it produces, and shifts one byte out on MOSI while shifting one byte in from MISO (SPI mode 3, CPOL=1/CPHA=1).
- Also owns the card chip-select.
- One start pulse yields exactly 8 SCLK periods, then the divider is left parked with SCLK high.

Parameters:
- IDLE_MOSI, 1'b1, level driven on MOSI when no transfer is active (SD idle-high convention).

Ports:
- clk  input  1  system clock (same clock as divider)
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to transfer tx_data; ignored while busy
- tx_data  input  8  byte to send, MSB first; sampled in the start cycle
- cs_req  input  1  1 = assert card chip-select
- busy  output  1  high from the cycle after accepted start until the transfer completes
- rx_data  output  8  last received byte, MSB first; holds until the next completion
- rx_valid  output  1  one-cycle pulse when rx_data updates
- div_en  output  1  enable to the clock divider (combinational, see below)
- sclk_in  input  1  divided clock from the divider (resets high)
- mosi  output  1  serial data to card
- miso  input  1  serial data from card
- cs_n  output  1  card chip-select, active low

Behaviour:
- Reset values: busy=0, rx_data=8'h00, rx_valid=0, mosi=IDLE_MOSI, cs_n=1, internal bit counter=0, sclk_q=1.
- Edge detection:
  - sclk_q is sclk_in registered each clk.
  - rise = sclk_in & ~sclk_q; fall = ~sclk_in & sclk_q.
  - Both are combinational and valid in the first cycle sclk_in shows its new value.
- cs_n is a register: cs_n <= ~cs_req every cycle. It is independent of busy; the user keeps cs_req stable across transfers.
- States: IDLE, XFER.
- IDLE:
  - On start=1, capture tx_data into tx_sh and rx_sh<=0, bit_cnt<=0, go XFER.
  - busy=1 and mosi=tx_data[7] from the next cycle.
- XFER, falling edge:
  - If bit_cnt!=0, tx_sh shifts left and mosi<=new tx_sh[7].
  - The first falling edge does not shift; MSB is already on the line.
- XFER, rising edge:
  - rx_sh <= {rx_sh[6:0], miso}; bit_cnt<=bit_cnt+1.
  - On the 8th rise (bit_cnt==7): rx_data<={rx_sh[6:0],miso}, rx_valid<=1 for one cycle, busy<=0, mosi<=IDLE_MOSI, go IDLE.
- div_en = (state==XFER) & ~(rise & bit_cnt==7).
  - div_en drops in the same cycle the 8th rise is seen, so the divider takes no further toggle even with divide value 0.
  - The divider's counter is left at 0, so every byte starts with identical phase.
- SCLK period = 2*(value+1) clk. A byte occupies 16*(value+1) clk from the first div_en cycle. Completion (rx_valid) occurs 1 cycle after the 8th sclk_in rise is registered.
- Back-to-back transfers:
  - start is accepted in the same cycle rx_valid is high (state already IDLE).
  - The next byte's first fall follows normally.
- start while busy: ignored, no effect on tx_sh or counters.
- Reset mid-transfer: immediate return to reset values; the transfer is abandoned with no rx_valid. The divider shares rst, so SCLK returns high.
- Edges on sclk_in while IDLE have no effect.

Test Plan:
- Divider value=0, start with tx_data=8'hA5, miso driven from 8'h3C on falling edges -> mosi bits 1,0,1,0,0,1,0,1 at the 8 rises; rx_data=8'h3C, rx_valid single pulse; exactly 8 sclk rises; sclk_in ends high; div_en low after.
- Divider value=3, tx_data=8'hFF, miso=0 -> SCLK half-period 4 clk, rx_data=8'h00, transfer length 64 clk from first div_en to last rise.
- Start on the rx_valid cycle with tx_data=8'h40 after 8'h51 -> second byte serialises correctly with no extra or missing SCLK edge; two rx_valid pulses.
- Start pulse asserted mid-transfer with tx_data=8'h00 during a 8'hC3 byte -> ignored; mosi still carries 8'hC3.
- rst asserted after 4th rise -> next cycle busy=0, cs_n=1, mosi=1, div_en=0, no rx_valid; a new 8'h12 transfer then completes normally.
- cs_req toggled 0->1->0 while idle -> cs_n follows inverted with 1-cycle latency; no SCLK activity.

Source files
------------

// File: rtl/sd_spi_byte.sv
// Byte-wide SPI mode-3 transceiver for an SD card. It gates an external clock
// divider and shifts one byte out on mosi while shifting one byte in from miso.
module sd_spi_byte #(
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       cs_req,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       div_en,
  input  logic       sclk_in,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        sclk_q;
  logic        busy_q, busy_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q;

  logic        rise;
  logic        fall;
  logic        last_rise;

  // Edges are visible in the first cycle sclk_in carries its new level.
  assign rise      = sclk_in & ~sclk_q;
  assign fall      = ~sclk_in & sclk_q;
  assign last_rise = rise & (bit_cnt_q == 3'd7);

  // Dropping the enable on the final rise leaves the divider parked high with
  // its counter at zero, so every byte starts from the same phase.
  assign div_en = (state_q == XFER) & ~last_rise;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sh_d   = tx_data;
          rx_sh_d   = 8'h00;
          bit_cnt_d = 3'd0;
          busy_d    = 1'b1;
          mosi_d    = tx_data[7];
          state_d   = XFER;
        end
      end

      XFER: begin
        // The MSB is already on the line before the first falling edge.
        if (fall && (bit_cnt_q != 3'd0)) begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
          mosi_d  = tx_sh_q[6];
        end
        if (rise) begin
          rx_sh_d   = {rx_sh_q[6:0], miso};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_sh_q[6:0], miso};
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            mosi_d     = IDLE_MOSI;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sclk_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      mosi_q     <= IDLE_MOSI;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_in;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= ~cs_req;
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_sd_spi_byte.sv
// Bench for sd_spi_byte: a behavioural clock divider and card model surround
// the DUT; table-driven byte transfers plus hand-written corner sequences.
module tb_sd_spi_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       cs_req;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       div_en;
  logic       sclk = 1'b1;
  logic       mosi;
  logic       miso = 1'b1;
  logic       cs_n;

  always #5 clk = ~clk;

  sd_spi_byte #(.IDLE_MOSI(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .cs_req   (cs_req),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .div_en   (div_en),
    .sclk_in  (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  // Divider model: toggles sclk every (div_val+1) enabled cycles; the card
  // model presents the next miso bit on each falling edge, MSB first.
  logic [7:0] div_val  = 8'd0;
  logic [7:0] div_cnt  = 8'd0;
  logic [7:0] miso_pat = 8'h00;
  logic [2:0] miso_idx = 3'd7;

  always @(posedge clk) begin
    if (rst) begin
      sclk    <= 1'b1;
      div_cnt <= 8'd0;
      miso    <= 1'b1;
    end else begin
      if (start && !busy) miso_idx <= 3'd7;
      if (div_en) begin
        if (div_cnt == div_val) begin
          div_cnt <= 8'd0;
          sclk    <= ~sclk;
          if (sclk) begin
            miso     <= miso_pat[miso_idx];
            miso_idx <= miso_idx - 3'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

  // Passive monitor: cumulative counters, the bench works with deltas.
  logic       sclk_prev = 1'b1;
  int         rises     = 0;
  int         pulses    = 0;
  int         en_cycles = 0;
  logic [7:0] mon_mosi  = 8'h00;

  always @(negedge clk) begin
    sclk_prev <= sclk;
    if (sclk && !sclk_prev) begin
      rises    <= rises + 1;
      mon_mosi <= {mon_mosi[6:0], mosi};
    end
    if (rx_valid) pulses <= pulses + 1;
    if (div_en) en_cycles <= en_cycles + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rxv(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input logic [7:0] tx, input logic [7:0] pat);
    tx_data  = tx;
    miso_pat = pat;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  typedef struct {
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_len;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string tag);
    int r0, p0, e0;
    bit ok;
    div_val = v.div;
    r0 = rises; p0 = pulses; e0 = en_cycles;
    issue(v.tx, v.pat);
    check({tag, "_busy_after_start"}, int'(busy), 1);
    check({tag, "_mosi_msb"}, int'(mosi), int'(v.tx[7]));
    wait_rxv(2000, ok);
    check({tag, "_rxv_seen"}, int'(ok), 1);
    check({tag, "_rx_data"}, int'(rx_data), int'(v.exp_rx));
    check({tag, "_mosi_bits"}, int'(mon_mosi), int'(v.exp_mosi));
    check({tag, "_rises"}, rises - r0, 8);
    check({tag, "_en_len"}, en_cycles - e0, v.exp_len);
    step(); step(); step();
    check({tag, "_rxv_pulses"}, pulses - p0, 1);
    check({tag, "_sclk_high"}, int'(sclk), 1);
    check({tag, "_div_en_low"}, int'(div_en), 0);
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_mosi_idle"}, int'(mosi), 1);
    $display("xfer %s: div=%0d tx=%02h rx=%02h mosi=%02h", tag, v.div, v.tx, rx_data, mon_mosi);
  endtask

  initial begin
    int r0, p0, e0;
    bit ok;

    vecs[0] = '{div: 8'd0, tx: 8'hA5, pat: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5, exp_len: 16};
    vecs[1] = '{div: 8'd3, tx: 8'hFF, pat: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF, exp_len: 64};
    vecs[2] = '{div: 8'd1, tx: 8'h81, pat: 8'hE7, exp_rx: 8'hE7, exp_mosi: 8'h81, exp_len: 32};
    vecs[3] = '{div: 8'd2, tx: 8'h00, pat: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00, exp_len: 48};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; cs_req = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_mosi", int'(mosi), 1);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_div_en", int'(div_en), 0);
    $display("reset: busy=%0b cs_n=%0b mosi=%0b", busy, cs_n, mosi);

    // Chip-select follows cs_req inverted with one cycle of latency.
    r0 = rises; e0 = en_cycles;
    cs_req = 1'b1;
    check("cs_before_edge", int'(cs_n), 1);
    step();
    check("cs_asserted", int'(cs_n), 0);
    cs_req = 1'b0;
    check("cs_hold", int'(cs_n), 0);
    step();
    check("cs_released", int'(cs_n), 1);
    step();
    check("cs_no_sclk", rises - r0, 0);
    check("cs_no_en", en_cycles - e0, 0);
    $display("cs toggle: cs_n=%0b", cs_n);
    cs_req = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: second start on the rx_valid cycle.
    div_val = 8'd0;
    r0 = rises; p0 = pulses; e0 = en_cycles;
    issue(8'h51, 8'hAA);
    wait_rxv(500, ok);
    check("b2b_first_seen", int'(ok), 1);
    check("b2b_first_rx", int'(rx_data), 8'hAA);
    check("b2b_first_mosi", int'(mon_mosi), 8'h51);
    issue(8'h40, 8'h96);
    check("b2b_second_busy", int'(busy), 1);
    wait_rxv(500, ok);
    check("b2b_second_seen", int'(ok), 1);
    check("b2b_second_rx", int'(rx_data), 8'h96);
    check("b2b_second_mosi", int'(mon_mosi), 8'h40);
    check("b2b_rises", rises - r0, 16);
    check("b2b_en_len", en_cycles - e0, 32);
    step(); step();
    check("b2b_pulses", pulses - p0, 2);
    $display("back-to-back: rx=%02h mosi=%02h rises=%0d", rx_data, mon_mosi, rises - r0);

    // Start while busy must be ignored.
    div_val = 8'd1;
    r0 = rises; p0 = pulses;
    issue(8'hC3, 8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rises - r0 >= 3) begin ok = 1'b1; break; end
      step();
    end
    check("ign_reach_rise3", int'(ok), 1);
    issue(8'h00, 8'h5A);
    wait_rxv(500, ok);
    check("ign_seen", int'(ok), 1);
    check("ign_mosi", int'(mon_mosi), 8'hC3);
    check("ign_rx", int'(rx_data), 8'h5A);
    check("ign_rises", rises - r0, 8);
    step(); step(); step();
    check("ign_pulses", pulses - p0, 1);
    check("ign_idle_after", int'(busy), 0);
    $display("ignored start: mosi=%02h rx=%02h", mon_mosi, rx_data);

    // Reset mid-transfer after the 4th rise.
    div_val = 8'd1;
    r0 = rises; p0 = pulses;
    issue(8'h77, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rises - r0 >= 4) begin ok = 1'b1; break; end
      step();
    end
    check("rstx_reach_rise4", int'(ok), 1);
    rst = 1'b1;
    step();
    check("rstx_busy", int'(busy), 0);
    check("rstx_cs_n", int'(cs_n), 1);
    check("rstx_mosi", int'(mosi), 1);
    check("rstx_div_en", int'(div_en), 0);
    rst = 1'b0;
    step(); step(); step();
    check("rstx_sclk_high", int'(sclk), 1);
    check("rstx_no_rxv", pulses - p0, 0);
    check("rstx_rx_data", int'(rx_data), 0);
    $display("reset mid-transfer: busy=%0b div_en=%0b pulses=%0d", busy, div_en, pulses - p0);
    run_vec('{div: 8'd1, tx: 8'h12, pat: 8'h6E, exp_rx: 8'h6E, exp_mosi: 8'h12, exp_len: 32},
            "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
